// File: rtl/sig_edge_mon.sv
`default_nettype none
// ============================================================================
// Module   : sig_edge_mon
// Purpose  : Multi-channel debounced edge monitor. Each channel runs a
//            4-state debounce FSM and produces a stable level, one-cycle
//            rise/fall pulses and a rising-edge event counter. A global
//            free-running timestamp counter is kept alongside.
// Options  : SIG_EDGE_MON_CNT_SAT_EN - when defined, event counters
//            saturate at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sig_edge_mon #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 16,
    parameter int DB_CYC = 4
) (
    input  logic                    mclk,
    input  logic                    mreset,
    input  logic                    en,
    input  logic                    clr,
    input  logic [CH_NUM-1:0]       din,
    output logic [CH_NUM-1:0]       dout_stable,
    output logic [CH_NUM-1:0]       rise_pls,
    output logic [CH_NUM-1:0]       fall_pls,
    output logic [CH_NUM*CNT_W-1:0] evt_cnt,
    output logic [CNT_W-1:0]        ts_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } state_t;

    // Value db_cnt holds on the sample that completes a debounce window.
    localparam logic [7:0]       c_DB_LAST = 8'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_ts_cnt;

    genvar i;
    generate
        for (i = 0; i < CH_NUM; i++) begin : g_ch
            state_t           r_state;
            state_t           w_state_nxt;
            logic [7:0]       r_db_cnt;
            logic [7:0]       w_db_nxt;
            logic             w_rise;
            logic             w_fall;
            logic             r_dout;
            logic             r_rise;
            logic             r_fall;
            logic [CNT_W-1:0] r_evt;

            // Debounce next-state: a level change is accepted only after
            // DB_CYC consecutive identical samples; any reversal aborts it.
            always_comb begin
                w_state_nxt = r_state;
                w_db_nxt    = r_db_cnt;
                w_rise      = 1'b0;
                w_fall      = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (din[i]) begin
                            w_state_nxt = ST_RISE_CHK;
                            w_db_nxt    = 8'd1;
                        end
                    end
                    ST_RISE_CHK: begin
                        if (!din[i]) begin
                            w_state_nxt = ST_IDLE;
                            w_db_nxt    = 8'd0;
                        end else if (r_db_cnt == c_DB_LAST) begin
                            w_state_nxt = ST_HIGH;
                            w_db_nxt    = 8'd0;
                            w_rise      = 1'b1;
                        end else begin
                            w_db_nxt    = r_db_cnt + 8'd1;
                        end
                    end
                    ST_HIGH: begin
                        if (!din[i]) begin
                            w_state_nxt = ST_FALL_CHK;
                            w_db_nxt    = 8'd1;
                        end
                    end
                    ST_FALL_CHK: begin
                        if (din[i]) begin
                            w_state_nxt = ST_HIGH;
                            w_db_nxt    = 8'd0;
                        end else if (r_db_cnt == c_DB_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_db_nxt    = 8'd0;
                            w_fall      = 1'b1;
                        end else begin
                            w_db_nxt    = r_db_cnt + 8'd1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_db_nxt    = 8'd0;
                    end
                endcase
            end

            // FSM state and registered level/pulse outputs; en=0 freezes
            // the FSM and squashes pulses.
            always_ff @(posedge mclk) begin
                if (mreset) begin
                    r_state  <= ST_IDLE;
                    r_db_cnt <= 8'd0;
                    r_dout   <= 1'b0;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                end else if (en) begin
                    r_state  <= w_state_nxt;
                    r_db_cnt <= w_db_nxt;
                    r_dout   <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALL_CHK);
                    r_rise   <= w_rise;
                    r_fall   <= w_fall;
                end else begin
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                end
            end

            // Rising-edge event counter; clr wins over a coincident rise.
            always_ff @(posedge mclk) begin
                if (mreset) begin
                    r_evt <= '0;
                end else if (clr) begin
                    r_evt <= '0;
                end else if (en && w_rise) begin
`ifdef SIG_EDGE_MON_CNT_SAT_EN
                    if (r_evt != c_CNT_MAX) begin
                        r_evt <= r_evt + 1'b1;
                    end
`else
                    r_evt <= r_evt + 1'b1;
`endif
                end
            end

            assign dout_stable[i]           = r_dout;
            assign rise_pls[i]              = r_rise;
            assign fall_pls[i]              = r_fall;
            assign evt_cnt[i*CNT_W +: CNT_W] = r_evt;
        end
    endgenerate

    // Free-running timestamp, always wrapping.
    always_ff @(posedge mclk) begin
        if (mreset) begin
            r_ts_cnt <= '0;
        end else if (clr) begin
            r_ts_cnt <= '0;
        end else if (en) begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
        end
    end

    assign ts_cnt = r_ts_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sig_edge_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig_edge_mon
// Purpose  : Self-checking bench for sig_edge_mon (4 channels, 2-bit
//            counters, 4-sample debounce). Expected outputs come from a
//            run-length reference model or from a hand-written vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sig_edge_mon;

    localparam int CH = 4;
    localparam int CW = 2;
    localparam int DB = 4;

    logic             mclk = 1'b0;
    logic             mreset;
    logic             en;
    logic             clr;
    logic [CH-1:0]    din;
    logic [CH-1:0]    dout_stable;
    logic [CH-1:0]    rise_pls;
    logic [CH-1:0]    fall_pls;
    logic [CH*CW-1:0] evt_cnt;
    logic [CW-1:0]    ts_cnt;

    sig_edge_mon #(.CH_NUM(CH), .CNT_W(CW), .DB_CYC(DB)) dut (
        .mclk       (mclk),
        .mreset     (mreset),
        .en         (en),
        .clr        (clr),
        .din        (din),
        .dout_stable(dout_stable),
        .rise_pls   (rise_pls),
        .fall_pls   (fall_pls),
        .evt_cnt    (evt_cnt),
        .ts_cnt     (ts_cnt)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic          en;
        logic          clr;
        logic [CH-1:0] din;
        logic [CH-1:0] stable;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } vec_t;

    typedef struct {
        string         tag;
        logic [CH-1:0] stable;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH*CW-1:0] evt;
        logic [CW-1:0] ts;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[18];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stable level plus count of consecutive differing samples.
    logic [CH-1:0]    m_stable;
    int               m_run[CH];
    logic [CH*CW-1:0] m_evt;
    logic [CW-1:0]    m_ts;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic [CH-1:0] d,
                        input string tag, input logic use_tab, input vec_t tv);
        logic [CH-1:0] rise_m;
        logic [CH-1:0] fall_m;
        logic [CW-1:0] cur;
        exp_t          ex;
        exp_t          got_e;
        @(negedge mclk);
        mreset = r; en = e; clr = c; din = d;
        rise_m = '0;
        fall_m = '0;
        if (r) begin
            m_stable = '0;
            for (int i = 0; i < CH; i++) m_run[i] = 0;
            m_evt = '0;
            m_ts  = '0;
        end else begin
            if (e) begin
                for (int i = 0; i < CH; i++) begin
                    if (d[i] !== m_stable[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_stable[i] = d[i];
                            if (d[i]) rise_m[i] = 1'b1;
                            else      fall_m[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            for (int i = 0; i < CH; i++) begin
                cur = m_evt[i*CW +: CW];
                if (c) cur = '0;
`ifdef SIG_EDGE_MON_CNT_SAT_EN
                else if (rise_m[i] && cur != {CW{1'b1}}) cur = cur + 1'b1;
`else
                else if (rise_m[i]) cur = cur + 1'b1;
`endif
                m_evt[i*CW +: CW] = cur;
            end
            if (c)      m_ts = '0;
            else if (e) m_ts = m_ts + 1'b1;
        end
        ex.tag    = tag;
        ex.stable = use_tab ? tv.stable : m_stable;
        ex.rise   = use_tab ? tv.rise   : rise_m;
        ex.fall   = use_tab ? tv.fall   : fall_m;
        ex.evt    = m_evt;
        ex.ts     = m_ts;
        sb_q.push_back(ex);
        @(posedge mclk);
        #1;
        got_e = sb_q.pop_front();
        check({got_e.tag, " lvl/rise/fall"}, {20'd0, dout_stable, rise_pls, fall_pls},
              {20'd0, got_e.stable, got_e.rise, got_e.fall});
        check({got_e.tag, " evt/ts"}, {22'd0, evt_cnt, ts_cnt}, {22'd0, got_e.evt, got_e.ts});
    endtask

    vec_t nv;
    int   exp_wrap;

    initial begin
        mreset = 1'b1; en = 1'b0; clr = 1'b0; din = '0;
        nv = '{1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        m_stable = '0; m_evt = '0; m_ts = '0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;

        // Hand-derived vectors (en=1, clr=0), starting from reset with din=0.
        vecs[0]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        vecs[4]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vecs[5]  = '{1'b1, 1'b0, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b1, 1'b0, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        vecs[7]  = '{1'b1, 1'b0, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        vecs[8]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vecs[9]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[10] = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[12] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vecs[13] = '{1'b1, 1'b0, 4'b1100, 4'b0001, 4'b0000, 4'b0000};
        vecs[14] = '{1'b1, 1'b0, 4'b1100, 4'b0001, 4'b0000, 4'b0000};
        vecs[15] = '{1'b1, 1'b0, 4'b1100, 4'b0001, 4'b0000, 4'b0000};
        vecs[16] = '{1'b1, 1'b0, 4'b1100, 4'b1100, 4'b1100, 4'b0001};
        vecs[17] = '{1'b1, 1'b0, 4'b1100, 4'b1100, 4'b0000, 4'b0000};

        // Reset held 2 cycles with all inputs high, then first rise after DB edges.
        step(1'b1, 1'b1, 1'b0, 4'hF, "rst0", 1'b0, nv);
        step(1'b1, 1'b1, 1'b0, 4'hF, "rst1", 1'b0, nv);
        for (int k = 0; k < DB + 1; k++) step(1'b0, 1'b1, 1'b0, 4'hF, "post_rst", 1'b0, nv);

        // Back to a clean IDLE start for the vector table.
        step(1'b1, 1'b1, 1'b0, 4'h0, "rst2", 1'b0, nv);
        for (int k = 0; k < 18; k++)
            step(1'b0, vecs[k].en, vecs[k].clr, vecs[k].din, $sformatf("vec%0d", k), 1'b1, vecs[k]);

        // en=0 through a 10-cycle pulse on ch1: nothing moves.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 4'b1110, "en_low", 1'b0, nv);
        for (int k = 0; k < 3; k++)  step(1'b0, 1'b1, 1'b0, 4'b1100, "en_high", 1'b0, nv);

        // clr coincident with a confirmed rise on ch0.
        for (int k = 0; k < DB - 1; k++) step(1'b0, 1'b1, 1'b0, 4'b1101, "pre_clr", 1'b0, nv);
        step(1'b0, 1'b1, 1'b1, 4'b1101, "clr_rise", 1'b0, nv);
        check("clr_rise pulse", {31'd0, rise_pls[0]}, 32'd1);
        check("clr_rise evt0", {30'd0, evt_cnt[1:0]}, 32'd0);
        check("clr_rise ts", {30'd0, ts_cnt}, 32'd0);

        // Five confirmed rises on ch2 with a 2-bit counter.
        step(1'b0, 1'b1, 1'b1, 4'b1101, "wrap_clr", 1'b0, nv);
        for (int k = 0; k < DB; k++) step(1'b0, 1'b1, 1'b0, 4'b1001, "wrap_fall", 1'b0, nv);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < DB; k++) step(1'b0, 1'b1, 1'b0, 4'b1101, "wrap_hi", 1'b0, nv);
            for (int k = 0; k < DB; k++) step(1'b0, 1'b1, 1'b0, 4'b1001, "wrap_lo", 1'b0, nv);
        end
`ifdef SIG_EDGE_MON_CNT_SAT_EN
        exp_wrap = 3;
`else
        exp_wrap = 1;
`endif
        check("evt2 after 5 rises", {30'd0, evt_cnt[5:4]}, exp_wrap);

        // Timestamp wraps 3->0: clear, then five enabled cycles.
        step(1'b0, 1'b1, 1'b1, 4'b1001, "ts_clr", 1'b0, nv);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 4'b1001, "ts_run", 1'b0, nv);
        check("ts wrap", {30'd0, ts_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
